// File: rtl/mac_issue_if.sv
// Host command, MAC core and response signals between mac_issue and its neighbours.
interface mac_issue_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_inst;
  logic [15:0] cmd_a;
  logic [15:0] cmd_b;
  logic        cmd_rd;

  logic [2:0]  instruction;
  logic [15:0] multiplier;
  logic [15:0] multiplicand;
  logic        stall;
  logic [31:0] result;
  logic [7:0]  protect;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [7:0]  rsp_protect;
  logic        rsp_ovf;

  modport slave (
    input  cmd_valid, cmd_inst, cmd_a, cmd_b, cmd_rd, result, protect, rsp_ready,
    output cmd_ready, instruction, multiplier, multiplicand, stall,
    output rsp_valid, rsp_result, rsp_protect, rsp_ovf
  );

  modport master (
    output cmd_valid, cmd_inst, cmd_a, cmd_b, cmd_rd, result, protect, rsp_ready,
    input  cmd_ready, instruction, multiplier, multiplicand, stall,
    input  rsp_valid, rsp_result, rsp_protect, rsp_ovf
  );
endinterface

// File: rtl/mac_issue.sv
// Issues buffered commands to the two-stage MAC core, flushes with 2 NOPs, then stalls; rd result is valid 4 edges after accept.
// Backpressure: cmd_ready drops when the command FIFO is full; rd commands wait for one of 2 credits, so responses are never dropped.
module mac_issue #(
  parameter int CMD_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  mac_issue_if.slave bus
);
  localparam int            AW       = $clog2(CMD_DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [2:0]    NOP_INST = 3'b010;

  typedef struct packed {
    logic [2:0]  inst;
    logic [15:0] a;
    logic [15:0] b;
    logic        rd;
  } cmd_t;

  typedef struct packed {
    logic [31:0] result;
    logic [7:0]  protect;
    logic        ovf;
  } rsp_t;

  cmd_t          cmd_mem [CMD_DEPTH];
  cmd_t          cmd_in;
  cmd_t          cmd_head;
  logic [AW-1:0] cmd_wp;
  logic [AW-1:0] cmd_rp;
  logic [AW:0]   cmd_cnt;
  logic          cmd_push;
  logic          cmd_empty;

  rsp_t          rsp_mem [2];
  rsp_t          rsp_in;
  rsp_t          rsp_head;
  logic          rsp_wp;
  logic          rsp_rp;
  logic [1:0]    rsp_cnt;
  logic          rsp_pop;

  logic          v1, r1, v2, r2, cap;
  logic [1:0]    out_rd;
  logic          issue_cmd;
  logic          issue_nop;
  logic          stall;

  // Count never exceeds CMD_DEPTH (a power of two), so its MSB alone means full.
  assign cmd_in        = {bus.cmd_inst, bus.cmd_a, bus.cmd_b, bus.cmd_rd};
  assign cmd_head      = cmd_mem[cmd_rp];
  assign cmd_empty     = (cmd_cnt == '0);
  assign cmd_push      = bus.cmd_valid & ~cmd_cnt[AW];
  assign bus.cmd_ready = ~cmd_cnt[AW];

  assign issue_cmd = ~cmd_empty & (~cmd_head.rd | (out_rd < 2'd2));
  assign issue_nop = ~issue_cmd & (v1 | v2);
  assign stall     = ~(issue_cmd | issue_nop);

  assign bus.stall        = stall;
  assign bus.instruction  = issue_cmd ? cmd_head.inst : NOP_INST;
  assign bus.multiplier   = issue_cmd ? cmd_head.a : 16'h0000;
  assign bus.multiplicand = issue_cmd ? cmd_head.b : 16'h0000;

  assign rsp_in          = {bus.result, bus.protect, (bus.protect != {8{bus.result[31]}})};
  assign rsp_head        = rsp_mem[rsp_rp];
  assign rsp_pop         = (rsp_cnt != 2'd0) & bus.rsp_ready;
  assign bus.rsp_valid   = (rsp_cnt != 2'd0);
  assign bus.rsp_result  = rsp_head.result;
  assign bus.rsp_protect = rsp_head.protect;
  assign bus.rsp_ovf     = rsp_head.ovf;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CMD_DEPTH; i++) cmd_mem[i] <= '0;
      cmd_wp  <= '0;
      cmd_rp  <= '0;
      cmd_cnt <= '0;
    end else begin
      if (cmd_push) begin
        cmd_mem[cmd_wp] <= cmd_in;
        cmd_wp          <= cmd_wp + PTR_ONE;
      end
      if (issue_cmd) cmd_rp <= cmd_rp + PTR_ONE;
      case ({cmd_push, issue_cmd})
        2'b10:   cmd_cnt <= cmd_cnt + CNT_ONE;
        2'b01:   cmd_cnt <= cmd_cnt - CNT_ONE;
        default: ;
      endcase
    end
  end

  // Credits bound responses in flight to 2, so a capture always finds a free slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_mem[0] <= '0;
      rsp_mem[1] <= '0;
      rsp_wp     <= 1'b0;
      rsp_rp     <= 1'b0;
      rsp_cnt    <= 2'd0;
    end else begin
      if (cap) begin
        rsp_mem[rsp_wp] <= rsp_in;
        rsp_wp          <= ~rsp_wp;
      end
      if (rsp_pop) rsp_rp <= ~rsp_rp;
      case ({cap, rsp_pop})
        2'b10:   rsp_cnt <= rsp_cnt + 2'd1;
        2'b01:   rsp_cnt <= rsp_cnt - 2'd1;
        default: ;
      endcase
    end
  end

  // Shadow of the core's operand pipeline; cap marks the cycle after an rd instruction executes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1     <= 1'b0;
      r1     <= 1'b0;
      v2     <= 1'b0;
      r2     <= 1'b0;
      cap    <= 1'b0;
      out_rd <= 2'd0;
    end else begin
      if (!stall) begin
        v1 <= issue_cmd;
        r1 <= issue_cmd & cmd_head.rd;
        v2 <= v1;
        r2 <= r1;
      end
      cap <= ~stall & v2 & r2;
      case ({issue_cmd & cmd_head.rd, rsp_pop})
        2'b10:   out_rd <= out_rd + 2'd1;
        2'b01:   out_rd <= out_rd - 2'd1;
        default: ;
      endcase
    end
  end
endmodule

// File: doc/mac_issue.md
# mac_issue

Command sequencer that drives the 16x16 MAC core's instruction/operand/stall port from a buffered command stream and returns selected accumulator values on a response handshake. It tracks the core's two-stage operand pipeline, inserts zero-effect NOPs to flush pending work, and freezes the core with `stall` when idle. A credit scheme keeps responses from ever being lost. It sits between the host command bus and the MAC core, and shares the core's clock and reset.

## Interface
- `CMD_DEPTH`, 4: command FIFO entries (power of two, ≥2).
- `clk` in 1: clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset. Shared with the MAC core.
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake. Transfer occurs on an edge where both are high.
- `cmd_inst` in 3: MAC instruction, 000–111.
- `cmd_a`, `cmd_b` in 16 each: multiplier and multiplicand.
- `cmd_rd` in 1: return the accumulator after this instruction executes.
- `instruction` out 3, `multiplier` out 16, `multiplicand` out 16, `stall` out 1: to the MAC core.
- `result` in 32, `protect` in 8: from the MAC core.
- `rsp_valid` out 1 / `rsp_ready` in 1: response handshake.
- `rsp_result` out 32, `rsp_protect` out 8, `rsp_ovf` out 1: captured values. `rsp_ovf` = (`protect` ≠ {8{`result[31]`}}), i.e. the 40-bit word view.

## Operation
- **Core model.** On an edge with `stall`=0, the core samples its inputs into stage 1, shifts stage 1 to stage 2, and executes stage 2. With `stall`=1 the whole core freezes.
- **NOP.** Instruction 010 with both operands 0; it adds zero in any mode.
- **Command FIFO.** `CMD_DEPTH` entries. `cmd_ready` = not full. There is no empty bypass: core outputs are driven only from FIFO head registers or NOP constants.
- **Shadow pipeline.** Two stages of valid/rd bits (v1/r1, v2/r2) that advance only on non-stall edges, plus a `cap` flag.
- **Credits.** The counter `out_rd` increments when an rd command issues and decrements on a response handshake. Its maximum is 2.
- **Issue priority, evaluated each cycle:**
  1. FIFO non-empty and (head `cmd_rd`=0 or `out_rd`<2): drive head, `stall`=0, pop at edge; set v1=1, r1=`cmd_rd`.
  2. Otherwise, if v1 or v2: drive NOP, `stall`=0; set v1=0.
  3. Otherwise: drive NOP values with `stall`=1.
- **Capture.** `cap` is set on a non-stall edge where v2 & r2. In the following cycle `result`/`protect` hold that instruction's outcome. At the next edge, stalled or not, they are pushed into the 2-entry response FIFO and `cap` clears, unless it is set again at the same edge. Credits guarantee the response FIFO has space.
- **Response FIFO.** Two entries, in-order. `rsp_*` are driven from the head. A simultaneous push and pop are allowed.
- **Reset.** All state clears when `reset_n` goes low, including mid-operation. Pending commands and responses are discarded.

## Timing
- **Reset values:**
  - `stall`=1, `instruction`=010, `multiplier`=`multiplicand`=0.
  - `rsp_valid`=0, `rsp_result`=0, `rsp_protect`=0, `rsp_ovf`=0.
  - `cmd_ready`=1.
- **Latency.** An rd command accepted at edge A into an empty, idle block:
  - issues at edge A+1 and executes at edge A+3;
  - `rsp_valid` is high after edge A+4.
- **Throughput.** One command per cycle while commands keep arriving.
- **Flush.** After the last real command issues, exactly 2 NOP edges follow, then `stall`=1.
- **Simultaneous events.** A FIFO push and pop on the same edge leave the count unchanged. With `cmd_valid` high while the FIFO is full, `cmd_ready` stays low and no data is lost.
- **`rsp_valid`.** Once high, it stays high with stable data until `rsp_ready`.

## Test plan
- Single 001 command, a=3, b=0xFFFC, rd=1 -> `rsp_result`=0xFFFFFFF4, `rsp_protect`=0xFF, `rsp_ovf`=0. `rsp_valid` rises 4 edges after accept, and `stall`=1 resumes after 2 NOPs.
- Accumulate overflow:
  - 001 then 010, 010, all with 0x7FFF×0x7FFF; rd on the last -> 0xBFFD0003, protect 0x00, ovf=1.
  - Then 011 with rd -> 0x7FFFFFFF, protect 0x00.
- 8-bit mode: 101 a=b=0x7F80, rd -> `rsp_result`=0x3F014000, `rsp_protect`=0x00.
- Backpressure: three back-to-back rd commands with `rsp_ready`=0 -> two responses buffered, third held (NOPs, then `stall`=1). Release `rsp_ready` -> all three delivered in order, values intact.
- Idle gap: 001 (2×3), 5 idle cycles, then 010 (1×1) rd -> response 7. Only 2 NOP edges occur in the gap; no double execution.
- Reset mid-flight: `reset_n` low with two commands in the pipe and one response queued -> `rsp_valid`=0, `stall`=1, `cmd_ready`=1. No stale response appears after release.
